// File: rtl/readout_sequencer.sv
// Event-level write sequencer for the 36-bit readout path: emits one header per event followed by
// that event's hit records, with truncation at MAX_HITS and an idle timeout that force-closes the event.
module readout_sequencer #(
    parameter int unsigned MAX_HITS = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        HdrReq,
    input  logic [22:0] HdrInfo,
    input  logic        EvtEmpty,
    input  logic        HitValid,
    input  logic [35:0] HitWords,
    input  logic        HitLast,
    input  logic        Full,
    output logic        HdrAck,
    output logic        HitRead,
    output logic        winc,
    output logic        ID_nData,
    output logic [11:0] Word0,
    output logic [11:0] Word1,
    output logic [11:0] Word2,
    output logic [23:0] Header,
    output logic        Busy,
    output logic        ErrPulse
);

    localparam int unsigned HCW = $clog2(MAX_HITS + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DROP
    } state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] hit_cnt_q, hit_cnt_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           err_flag_q, err_flag_d;
    logic [HCW-1:0] hit_inc;
    logic [TCW-1:0] to_inc;

    assign hit_inc = hit_cnt_q + HCW'(1);
    assign to_inc  = to_cnt_q + TCW'(1);

    // Payload fields pass straight through; only winc qualifies them.
    assign Word0  = HitWords[11:0];
    assign Word1  = HitWords[23:12];
    assign Word2  = HitWords[35:24];
    assign Header = {err_flag_q, HdrInfo};
    assign Busy   = (state_q != S_IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            hit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_flag_d = err_flag_q;
        HdrAck     = 1'b0;
        HitRead    = 1'b0;
        winc       = 1'b0;
        ID_nData   = 1'b0;
        ErrPulse   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (HdrReq) begin
                    state_d = S_HDR;
                end
            end

            // Header goes out carrying the previous event's error, then the flag restarts.
            S_HDR: begin
                if (!Full) begin
                    winc       = 1'b1;
                    ID_nData   = 1'b1;
                    HdrAck     = 1'b1;
                    hit_cnt_d  = '0;
                    to_cnt_d   = '0;
                    err_flag_d = 1'b0;
                    state_d    = EvtEmpty ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (HitValid) begin
                    if (!Full) begin
                        winc      = 1'b1;
                        HitRead   = 1'b1;
                        hit_cnt_d = hit_inc;
                        to_cnt_d  = '0;
                        if (HitLast) begin
                            state_d = S_IDLE;
                        end else if (hit_inc == HCW'(MAX_HITS)) begin
                            state_d    = S_DROP;
                            err_flag_d = 1'b1;
                            ErrPulse   = 1'b1;
                        end
                    end
                end else begin
                    to_cnt_d = to_inc;
                    if (to_inc == TCW'(TIMEOUT)) begin
                        state_d    = S_IDLE;
                        err_flag_d = 1'b1;
                        ErrPulse   = 1'b1;
                    end
                end
            end

            // Excess records are drained without writing, independent of backpressure.
            S_DROP: begin
                if (HitValid) begin
                    HitRead  = 1'b1;
                    to_cnt_d = '0;
                    if (HitLast) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    to_cnt_d = to_inc;
                    if (to_inc == TCW'(TIMEOUT)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized and directed bench for readout_sequencer, checked every cycle against an event-level model.
module tb_readout_sequencer;

    localparam int MAXH = 16;
    localparam int TO   = 8;

    logic        Clk, Reset;
    logic        HdrReq, EvtEmpty, HitValid, HitLast, Full;
    logic [22:0] HdrInfo;
    logic [35:0] HitWords;
    logic        HdrAck, HitRead, winc, ID_nData, Busy, ErrPulse;
    logic [11:0] Word0, Word1, Word2;
    logic [23:0] Header;

    readout_sequencer #(.MAX_HITS(MAXH), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .HdrReq(HdrReq), .HdrInfo(HdrInfo), .EvtEmpty(EvtEmpty),
        .HitValid(HitValid), .HitWords(HitWords), .HitLast(HitLast), .Full(Full),
        .HdrAck(HdrAck), .HitRead(HitRead), .winc(winc), .ID_nData(ID_nData),
        .Word0(Word0), .Word1(Word1), .Word2(Word2), .Header(Header), .Busy(Busy),
        .ErrPulse(ErrPulse)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    // Event-level model: is an event open, is its header still owed, is it dropping, counts, error.
    bit m_active, m_need_hdr, m_drop, m_err;
    int m_hits, m_idle;
    bit e_ack, e_read, e_winc, e_id, e_errp, e_busy;

    // Tallies of observed DUT activity for hand-computed expectations.
    int cyc, cnt_winc, cnt_dwr, cnt_drop, cnt_read, cnt_errp, cnt_busy_nw, first_w, last_w;
    logic [23:0] last_hdr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_need_hdr = 0; m_drop = 0; m_err = 0; m_hits = 0; m_idle = 0;
        e_ack = 0; e_read = 0;
    endtask

    task automatic close_event();
        m_active = 0;
        m_drop   = 0;
    endtask

    task automatic model_check();
        logic [23:0] e_hdr;
        e_busy = m_active;
        e_hdr  = {m_err, HdrInfo};
        e_ack = 0; e_read = 0; e_winc = 0; e_id = 0; e_errp = 0;
        if (!m_active) begin
            if (HdrReq) begin
                m_active   = 1;
                m_need_hdr = 1;
            end
        end else if (m_need_hdr) begin
            if (!Full) begin
                e_winc = 1; e_id = 1; e_ack = 1;
                m_err = 0; m_hits = 0; m_idle = 0; m_need_hdr = 0;
                if (EvtEmpty) close_event();
            end
        end else if (HitValid) begin
            if (m_drop) begin
                e_read = 1;
                m_idle = 0;
                if (HitLast) close_event();
            end else if (!Full) begin
                e_winc = 1; e_read = 1;
                m_hits++;
                m_idle = 0;
                if (HitLast) close_event();
                else if (m_hits == MAXH) begin
                    m_drop = 1; m_err = 1; e_errp = 1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                if (!m_drop) e_errp = 1;
                m_err = 1;
                close_event();
            end
        end
        chk("winc", winc, e_winc);
        chk("hdr_ack", HdrAck, e_ack);
        chk("hit_read", HitRead, e_read);
        chk("busy", Busy, e_busy);
        chk("err_pulse", ErrPulse, e_errp);
        if (e_winc) chk("id_ndata", ID_nData, e_id);
        if (e_winc && e_id) chk("header", Header, e_hdr);
        if (e_winc && !e_id) chk("data_words", {Word2, Word1, Word0}, HitWords);
    endtask

    // One clock: sample and compare at negedge, then return just after the next rising edge.
    task automatic step();
        @(negedge Clk);
        model_check();
        cyc++;
        if (winc) begin
            cnt_winc++;
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
            if (ID_nData) last_hdr = Header;
            else cnt_dwr++;
        end
        if (HitRead) cnt_read++;
        if (HitRead && !winc) cnt_drop++;
        if (ErrPulse) cnt_errp++;
        if (Busy && !winc) cnt_busy_nw++;
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_tally();
        cnt_winc = 0; cnt_dwr = 0; cnt_drop = 0; cnt_read = 0; cnt_errp = 0;
        cnt_busy_nw = 0; first_w = -1; last_w = -1;
    endtask

    task automatic send_hdr(input logic [22:0] info, input logic empty);
        bit got;
        got = 0;
        HdrReq = 1; HdrInfo = info; EvtEmpty = empty;
        for (int i = 0; i < 64 && !got; i++) begin
            step();
            got = e_ack;
        end
        chk("hdr_ack_wait", 64'(got), 64'd1);
        HdrReq = 0;
    endtask

    task automatic send_hit(input logic [35:0] w, input logic last);
        bit got;
        got = 0;
        HitValid = 1; HitWords = w; HitLast = last;
        for (int i = 0; i < 64 && !got; i++) begin
            step();
            got = e_read;
        end
        chk("hit_read_wait", 64'(got), 64'd1);
        HitValid = 0; HitLast = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            step();
            if (!Busy) break;
        end
    endtask

    task automatic do_reset();
        Reset = 1;
        #1;
        chk("rst_winc", winc, 0);
        chk("rst_hdrack", HdrAck, 0);
        chk("rst_hitread", HitRead, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_errpulse", ErrPulse, 0);
        chk("rst_id_ndata", ID_nData, 0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 0;
    endtask

    logic [63:0] r64;
    int pause;

    initial begin
        Reset = 1; HdrReq = 0; HdrInfo = '0; EvtEmpty = 0; HitValid = 0; HitWords = '0;
        HitLast = 0; Full = 0; cyc = 0; last_hdr = '0; pause = 0;
        clear_tally();
        @(posedge Clk);
        do_reset();

        // 1: header-only event
        clear_tally();
        send_hdr(23'h12345, 1);
        chk("t1_winc_count", cnt_winc, 1);
        chk("t1_header", last_hdr, 24'h012345);
        step();
        chk("t1_back_idle", Busy, 0);

        // 2: header plus three records back to back
        clear_tally();
        send_hdr(23'h00abc, 0);
        send_hit(36'h111222333, 0);
        send_hit(36'h444555666, 0);
        send_hit(36'h777888999, 1);
        chk("t2_winc_count", cnt_winc, 4);
        chk("t2_read_count", cnt_read, 3);
        chk("t2_consecutive", last_w - first_w, 3);

        // 3: backpressure for five cycles mid-event
        clear_tally();
        send_hdr(23'h00def, 0);
        send_hit(36'haaa000001, 0);
        Full = 1; HitValid = 1; HitWords = 36'haaa000002; HitLast = 0;
        repeat (5) step();
        chk("t3_stall_winc", cnt_winc, 2);
        chk("t3_stall_read", cnt_read, 1);
        Full = 0;
        send_hit(36'haaa000002, 0);
        send_hit(36'haaa000003, 1);
        chk("t3_data_writes", cnt_dwr, 3);
        chk("t3_reads", cnt_read, 3);

        // 4: 20 records, truncated at 16
        clear_tally();
        send_hdr(23'h000444, 0);
        for (int i = 0; i < 20; i++) send_hit(36'(i + 36'h500000000), (i == 19));
        chk("t4_data_writes", cnt_dwr, 16);
        chk("t4_dropped", cnt_drop, 4);
        chk("t4_err_pulses", cnt_errp, 1);
        step();
        send_hdr(23'h000001, 1);
        chk("t4_next_errflag", last_hdr[23], 1);

        // 5: idle timeout in DATA
        clear_tally();
        send_hdr(23'h000002, 0);
        wait_idle();
        chk("t5_idle_cycles", cnt_busy_nw, TO);
        chk("t5_err_pulses", cnt_errp, 1);

        // 6: reset mid-event, next event is clean
        clear_tally();
        send_hdr(23'h000003, 0);
        chk("t5_next_errflag", last_hdr[23], 1);
        send_hit(36'h600000001, 0);
        send_hit(36'h600000002, 0);
        HitValid = 1; HitWords = 36'h600000003;
        do_reset();
        HitValid = 0;
        send_hdr(23'h07abcd, 1);
        chk("t6_clean_header", last_hdr, 24'h07abcd);

        // Reset must also clear a pending error flag
        send_hdr(23'h000005, 0);
        wait_idle();
        do_reset();
        send_hdr(23'h000006, 1);
        chk("t6_reset_clears_err", last_hdr, 24'h000006);

        // Random traffic with protocol-following sources
        for (int c = 0; c < 4000; c++) begin
            if (HdrReq && e_ack) HdrReq = 0;
            else if (!HdrReq && $urandom_range(0, 5) == 0) begin
                HdrReq   = 1;
                HdrInfo  = 23'($urandom);
                EvtEmpty = ($urandom_range(0, 3) == 0);
            end
            if (HitValid && e_read) begin
                HitValid = 0;
                HitLast  = 0;
            end
            if (pause > 0) pause--;
            else if (!HitValid) begin
                if ($urandom_range(0, 30) == 0) pause = $urandom_range(1, 12);
                else if ($urandom_range(0, 3) != 0) begin
                    r64      = {$urandom, $urandom};
                    HitValid = 1;
                    HitWords = r64[35:0];
                    HitLast  = ($urandom_range(0, 11) == 0);
                end
            end
            Full = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
